fetch_arbiter: RTL and testbench

FETCH_ARBITER -- requirements
Module: fetch_arbiter

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_queue.sv | 84 ++++++++
 rtl/fetch_arbiter.sv | 131 +++++++++++++
 tb/tb_fetch_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and FSM encoding for the instruction fetch / load-store arbiter.
package fetch_pkg;

    localparam int BITS_DATA_DEF   = 32;
    localparam int BITS_ADDR_DEF   = 16;
    localparam int QUEUE_DEPTH_DEF = 4;

    localparam logic [4:0] HLT_OPCODE = 5'b11111;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        LS_ACK = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue: small circular FIFO with flush, occupancy count and full/empty flags.
module fetch_queue #(
    parameter int DATA_W = 48,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_arbiter.sv
// Shares one memory port between instruction fetch (into a queue) and load-store
// accesses; load-store wins, a fetched HLT word stops fetching until a redirect.
module fetch_arbiter
    import fetch_pkg::*;
#(
    parameter int BITS_DATA   = BITS_DATA_DEF,
    parameter int BITS_ADDR   = BITS_ADDR_DEF,
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [BITS_ADDR-1:0] mem_address,
    output logic [BITS_DATA-1:0] mem_wdata,
    output logic                 mem_write,
    input  logic [BITS_DATA-1:0] mem_rdata,
    input  logic                 ls_req,
    input  logic                 ls_write,
    input  logic [BITS_ADDR-1:0] ls_addr,
    input  logic [BITS_DATA-1:0] ls_wdata,
    output logic                 ls_ack,
    output logic [BITS_DATA-1:0] ls_rdata,
    input  logic                 redirect_valid,
    input  logic [BITS_ADDR-1:0] redirect_addr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [BITS_DATA-1:0] instr_word,
    output logic [BITS_ADDR-1:0] instr_pc
);

    localparam int ENTRY_W = BITS_DATA + BITS_ADDR;
    localparam int CNT_W   = $clog2(QUEUE_DEPTH + 1);

    fetch_state_t         state_q, state_d;
    logic [BITS_ADDR-1:0] pc_q, pc_d;
    logic                 ret_halt_q, ret_halt_d;
    logic [BITS_DATA-1:0] ls_rdata_q, ls_rdata_d;

    logic                 halted;
    logic                 ls_issue;
    logic                 do_fetch;
    logic                 fetch_hlt;
    logic                 q_pop;
    logic [ENTRY_W-1:0]   q_head;
    logic [CNT_W-1:0]     q_count;
    logic                 q_full;
    logic                 q_empty;

    always_comb begin
        // An acknowledge cycle that returns to HALTED must not fetch either.
        halted    = (state_q == HALTED) || ((state_q == LS_ACK) && ret_halt_q);
        ls_issue  = ls_req && (state_q != LS_ACK) && !reset;
        do_fetch  = !ls_issue && !halted && !redirect_valid && !q_full && !reset;
        fetch_hlt = (mem_rdata[BITS_DATA-1 -: 5] == HLT_OPCODE);

        mem_address = ls_issue ? ls_addr : pc_q;
        mem_wdata   = ls_issue ? ls_wdata : '0;
        mem_write   = ls_issue && ls_write;

        state_d    = state_q;
        pc_d       = pc_q;
        ret_halt_d = ret_halt_q;
        ls_rdata_d = ls_rdata_q;

        case (state_q)
            LS_ACK: begin
                state_d = ret_halt_q ? HALTED : FETCH;
            end
            default: begin
                if (ls_issue) begin
                    state_d    = LS_ACK;
                    ret_halt_d = (state_q == HALTED) && !redirect_valid;
                    ls_rdata_d = mem_rdata;
                end
            end
        endcase

        // The PC parks on the HLT word so the address past it is never presented.
        if (do_fetch) begin
            if (fetch_hlt) begin
                state_d = HALTED;
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end

        if (redirect_valid) begin
            pc_d = redirect_addr;
            if (state_d == HALTED) begin
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= '0;
            ret_halt_q <= 1'b0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ret_halt_q <= ret_halt_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    fetch_queue #(
        .DATA_W (ENTRY_W),
        .DEPTH  (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (do_fetch),
        .pop   (q_pop),
        .flush (redirect_valid),
        .wdata ({mem_rdata, pc_q}),
        .rdata (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign instr_valid = (q_count != '0) && !redirect_valid;
    assign q_pop       = instr_ready && !q_empty && !redirect_valid;
    assign instr_word  = q_head[ENTRY_W-1 -: BITS_DATA];
    assign instr_pc    = q_head[BITS_ADDR-1:0];
    assign ls_ack      = (state_q == LS_ACK);
    assign ls_rdata    = ls_rdata_q;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed scenarios plus a randomized run against an instruction-stream / load-store model.
module tb_fetch_arbiter;
    import fetch_pkg::*;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;
    logic          ls_req = 1'b0;
    logic          ls_write = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic          ls_ack;
    logic [DW-1:0] ls_rdata;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [DW-1:0] instr_word;
    logic [AW-1:0] instr_pc;

    logic [DW-1:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    fetch_arbiter #(
        .BITS_DATA   (DW),
        .BITS_ADDR   (AW),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_write      (mem_write),
        .mem_rdata      (mem_rdata),
        .ls_req         (ls_req),
        .ls_write       (ls_write),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_ack         (ls_ack),
        .ls_rdata       (ls_rdata),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_word     (instr_word),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_address];

    always @(negedge clk) begin
        if (mem_write) mem[mem_address] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ls_req = 1'b0;
        ls_write = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic is_hlt(input logic [DW-1:0] word);
        return word[31:27] == HLT_OPCODE;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: observed time limit expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] old_w;
        logic [AW-1:0] got_pc[$];
        logic [DW-1:0] got_w[$];
        logic [AW-1:0] exp_p[$];
        logic [DW-1:0] exp_w[$];
        logic [AW-1:0] addr0, addr1, exp_pc;
        logic [DW-1:0] ls_model [16];
        logic          found, halted_m, ack_exp, issue, issued, pend_write;
        int            seen10, pend_idx, idx;

        for (int i = 0; i < 65536; i++) mem[i] = '0;
        for (int i = 0; i < 9; i++) begin
            w = $urandom();
            w[31] = 1'b0;
            mem[i] = w;
        end
        mem[9] = 32'hF800_0000;
        mem[10] = 32'h0000_0AAA;
        w = $urandom();
        w[31] = 1'b0;
        mem[16'hFFFF] = w;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_ls_ack", 64'(ls_ack), 64'(0));
        check("rst_ls_rdata", 64'(ls_rdata), 64'(0));
        check("rst_instr_valid", 64'(instr_valid), 64'(0));
        check("rst_mem_write", 64'(mem_write), 64'(0));
        check("rst_mem_address", 64'(mem_address), 64'(0));

        // Program run to HLT
        do_reset();
        instr_ready = 1'b1;
        seen10 = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (mem_address == 16'd10) seen10++;
            if (instr_valid && instr_ready) begin
                got_pc.push_back(instr_pc);
                got_w.push_back(instr_word);
            end
        end
        for (int i = 0; i < 64; i++) begin
            exp_p.push_back(AW'(i));
            exp_w.push_back(mem[i]);
            if (is_hlt(mem[i])) break;
        end
        check("prog_count", 64'(got_pc.size()), 64'(exp_p.size()));
        for (int i = 0; i < got_pc.size() && i < exp_p.size(); i++) begin
            check($sformatf("prog_pc_%0d", i), 64'(got_pc[i]), 64'(exp_p[i]));
            check($sformatf("prog_word_%0d", i), 64'(got_w[i]), 64'(exp_w[i]));
        end
        check("prog_addr10_seen", 64'(seen10), 64'(0));
        check("prog_halted", 64'(dut.state_q), 64'(HALTED));
        check("prog_addr_hold", 64'(mem_address), 64'(9));

        // Decoder stalled: queue fills then fetch holds
        do_reset();
        instr_ready = 1'b0;
        repeat (8) step();
        @(negedge clk);
        check("stall_addr", 64'(mem_address), 64'(4));
        check("stall_count", 64'(dut.q_count), 64'(QD));
        check("stall_valid", 64'(instr_valid), 64'(1));
        check("stall_head_pc", 64'(instr_pc), 64'(0));
        check("stall_head_word", 64'(instr_word), 64'(mem[0]));

        // Store then load through the shared port
        do_reset();
        instr_ready = 1'b1;
        repeat (3) step();
        ls_req = 1'b1;
        ls_write = 1'b1;
        ls_addr = 16'h8000;
        ls_wdata = 32'h0000_000D;
        @(negedge clk);
        check("st_mem_write", 64'(mem_write), 64'(1));
        check("st_mem_addr", 64'(mem_address), 64'(16'h8000));
        check("st_mem_wdata", 64'(mem_wdata), 64'(32'h0000_000D));
        check("st_no_ack", 64'(ls_ack), 64'(0));
        step();
        ls_req = 1'b0;
        ls_write = 1'b0;
        @(negedge clk);
        check("st_ack", 64'(ls_ack), 64'(1));
        check("st_ack_no_write", 64'(mem_write), 64'(0));
        check("st_fetch_resume", 64'(mem_address), 64'(3));
        step();
        @(negedge clk);
        check("st_ack_once", 64'(ls_ack), 64'(0));
        check("st_fetch_next", 64'(mem_address), 64'(4));
        check("st_mem_content", 64'(mem[16'h8000]), 64'(32'h0000_000D));
        step();
        ls_req = 1'b1;
        ls_write = 1'b0;
        ls_addr = 16'h8000;
        @(negedge clk);
        check("ld_mem_write", 64'(mem_write), 64'(0));
        check("ld_mem_addr", 64'(mem_address), 64'(16'h8000));
        step();
        ls_req = 1'b0;
        @(negedge clk);
        check("ld_ack", 64'(ls_ack), 64'(1));
        check("ld_rdata", 64'(ls_rdata), 64'(32'h0000_000D));

        // Asynchronous reset in the middle of a store
        step();
        old_w = mem[16'h8001];
        ls_req = 1'b1;
        ls_write = 1'b1;
        ls_addr = 16'h8001;
        ls_wdata = 32'hDEAD_BEEF;
        #2;
        reset = 1'b1;
        #1;
        check("arst_mem_write", 64'(mem_write), 64'(0));
        check("arst_ls_ack", 64'(ls_ack), 64'(0));
        check("arst_ls_rdata", 64'(ls_rdata), 64'(0));
        check("arst_instr_valid", 64'(instr_valid), 64'(0));
        check("arst_mem_addr", 64'(mem_address), 64'(0));
        @(negedge clk);
        #1;
        ls_req = 1'b0;
        ls_write = 1'b0;
        check("arst_no_store", 64'(mem[16'h8001]), 64'(old_w));

        // Redirect flushes a partly filled queue
        do_reset();
        instr_ready = 1'b0;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_addr = 16'h0006;
        @(negedge clk);
        check("rd_valid_low", 64'(instr_valid), 64'(0));
        step();
        redirect_valid = 1'b0;
        check("rd_flushed", 64'(dut.q_count), 64'(0));
        instr_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (!found && instr_valid) begin
                found = 1'b1;
                check("rd_first_pc", 64'(instr_pc), 64'(6));
                check("rd_first_word", 64'(instr_word), 64'(mem[6]));
            end
        end
        check("rd_delivered", 64'(found), 64'(1));

        // Redirect to the top of the address space wraps
        do_reset();
        instr_ready = 1'b1;
        repeat (2) step();
        redirect_valid = 1'b1;
        redirect_addr = 16'hFFFF;
        @(negedge clk);
        check("wrap_valid_low", 64'(instr_valid), 64'(0));
        step();
        redirect_valid = 1'b0;
        got_pc.delete();
        addr0 = '0;
        addr1 = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) addr0 = mem_address;
            if (c == 1) addr1 = mem_address;
            if (instr_valid && instr_ready) got_pc.push_back(instr_pc);
            step();
        end
        check("wrap_addr0", 64'(addr0), 64'(16'hFFFF));
        check("wrap_addr1", 64'(addr1), 64'(16'h0000));
        check("wrap_delivered", 64'(got_pc.size() >= 2), 64'(1));
        if (got_pc.size() >= 2) begin
            check("wrap_pc0", 64'(got_pc[0]), 64'(16'hFFFF));
            check("wrap_pc1", 64'(got_pc[1]), 64'(16'h0000));
        end

        // Randomized traffic against the instruction-stream and load-store model
        for (int i = 0; i < 2048; i++) begin
            w = $urandom();
            if ($urandom_range(15) == 0) w[31:27] = HLT_OPCODE;
            else w[31] = 1'b0;
            mem[i] = w;
        end
        for (int i = 0; i < 16; i++) ls_model[i] = mem[16'h8000 + i];
        do_reset();
        exp_pc = '0;
        halted_m = 1'b0;
        issued = 1'b0;
        pend_write = 1'b0;
        pend_idx = 0;
        idx = 0;
        for (int n = 0; n < 600; n++) begin
            ack_exp = issued;
            idx = int'($urandom_range(15));
            ls_write = 1'($urandom_range(1));
            ls_addr = 16'h8000 | AW'(idx);
            ls_wdata = $urandom();
            if (ack_exp) begin
                issue = 1'b0;
                ls_req = 1'($urandom_range(1));
            end else begin
                issue = ($urandom_range(4) == 0);
                ls_req = issue;
            end
            redirect_valid = ($urandom_range(11) == 0);
            redirect_addr = AW'($urandom_range(1023));
            instr_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            check("rnd_ls_ack", 64'(ls_ack), 64'(ack_exp));
            if (ack_exp && !pend_write) check("rnd_ld_data", 64'(ls_rdata), 64'(ls_model[pend_idx]));
            if (issue) begin
                check("rnd_ls_write", 64'(mem_write), 64'(ls_write));
                check("rnd_ls_addr", 64'(mem_address), 64'(ls_addr));
                if (ls_write) begin
                    check("rnd_ls_wdata", 64'(mem_wdata), 64'(ls_wdata));
                    ls_model[idx] = ls_wdata;
                end
            end else begin
                check("rnd_no_write", 64'(mem_write), 64'(0));
            end
            if (redirect_valid) begin
                check("rnd_valid_redirect", 64'(instr_valid), 64'(0));
                exp_pc = redirect_addr;
                halted_m = 1'b0;
            end else if (halted_m) begin
                check("rnd_after_hlt", 64'(instr_valid), 64'(0));
            end else if (instr_valid && instr_ready) begin
                check("rnd_instr_pc", 64'(instr_pc), 64'(exp_pc));
                check("rnd_instr_word", 64'(instr_word), 64'(mem[exp_pc]));
                halted_m = is_hlt(mem[exp_pc]);
                exp_pc = exp_pc + 1'b1;
            end
            issued = issue;
            if (issue) begin
                pend_write = ls_write;
                pend_idx = idx;
            end
            step();
        end
        ls_req = 1'b0;
        redirect_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
